// File: rtl/bus_driver_arbiter.sv
// Round-robin owner arbitration for the shared datapath bus: one-hot grant,
// encoded mux select, forced turnaround between owners and a hold limit under contention.
module bus_driver_arbiter #(
  parameter int N_SRC    = 24,
  parameter int SEL_W    = 5,
  parameter int TURN_CYC = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             bus_valid,
  output logic             preempt
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam int IDX_W  = SEL_W + 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t             state_reg, state_next;
  logic [N_SRC-1:0]   gnt_reg, gnt_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic               bus_valid_reg, bus_valid_next;
  logic               preempt_reg, preempt_next;
  logic [SEL_W-1:0]   rr_reg, rr_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic [TURN_W-1:0]  turn_reg, turn_next;

  logic [SEL_W-1:0]   cand [N_SRC];
  logic [N_SRC-1:0]   hit;
  logic [SEL_W-1:0]   win_idx;
  logic               win_found;
  logic               owner_req;
  logic               other_req;

  // Candidate gi is the (gi+1)-th source after the last winner, wrapping at N_SRC.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cand
      logic [IDX_W-1:0] sum;
      assign sum      = {1'b0, rr_reg} + IDX_W'(gi + 1);
      assign cand[gi] = (sum >= IDX_W'(N_SRC)) ? SEL_W'(sum - IDX_W'(N_SRC))
                                               : sum[SEL_W-1:0];
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    win_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (hit[i]) win_idx = cand[i];
    end
  end

  assign win_found = |hit;
  assign owner_req = |(req & gnt_reg);
  assign other_req = |(req & ~gnt_reg);

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    sel_next       = sel_reg;
    bus_valid_next = bus_valid_reg;
    preempt_next   = 1'b0;
    rr_next        = rr_reg;
    hold_next      = hold_reg;
    turn_next      = turn_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next     = GRANT;
          gnt_next       = N_SRC'(1) << win_idx;
          sel_next       = win_idx;
          bus_valid_next = 1'b1;
          rr_next        = win_idx;
          hold_next      = HOLD_W'(1);
        end
      end
      GRANT: begin
        // Release has priority over preemption when both apply on the same edge.
        if (!owner_req || (hold_reg == HOLD_W'(HOLD_MAX) && other_req)) begin
          state_next     = TURN;
          gnt_next       = '0;
          sel_next       = '0;
          bus_valid_next = 1'b0;
          preempt_next   = owner_req;
          turn_next      = TURN_W'(TURN_CYC - 1);
        end else if (hold_reg != HOLD_W'(HOLD_MAX)) begin
          hold_next = hold_reg + HOLD_W'(1);
        end
      end
      TURN: begin
        if (turn_reg == '0) begin
          state_next = IDLE;
          hold_next  = '0;
        end else begin
          turn_next = turn_reg - TURN_W'(1);
        end
      end
      default: begin
        state_next     = IDLE;
        gnt_next       = '0;
        sel_next       = '0;
        bus_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      sel_reg       <= '0;
      bus_valid_reg <= 1'b0;
      preempt_reg   <= 1'b0;
      rr_reg        <= SEL_W'(N_SRC - 1);
      hold_reg      <= '0;
      turn_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      sel_reg       <= sel_next;
      bus_valid_reg <= bus_valid_next;
      preempt_reg   <= preempt_next;
      rr_reg        <= rr_next;
      hold_reg      <= hold_next;
      turn_reg      <= turn_next;
    end
  end

  assign gnt       = gnt_reg;
  assign sel       = sel_reg;
  assign bus_valid = bus_valid_reg;
  assign preempt   = preempt_reg;

endmodule

// File: tb/tb_bus_driver_arbiter.sv
// Directed bench for bus_driver_arbiter: expected grant transactions are queued by
// the stimulus and checked by an independent monitor as each grant starts and ends.
module tb_bus_driver_arbiter;

  localparam int N_SRC = 24;
  localparam int SEL_W = 5;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic [N_SRC-1:0] req = '0;
  logic [N_SRC-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             bus_valid;
  logic             preempt;

  bus_driver_arbiter #(.N_SRC(N_SRC), .SEL_W(SEL_W), .TURN_CYC(1), .HOLD_MAX(8)) dut (
    .clk(clk), .clr(clr), .req(req), .gnt(gnt), .sel(sel),
    .bus_valid(bus_valid), .preempt(preempt)
  );

  always #5 clk = ~clk;

  // len = grant cycles (0 means cut short by reset), gap = idle cycles before it (-1 = don't care)
  typedef struct {
    int sel;
    int len;
    bit pre;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic push(input int s, input int l, input bit p, input int g);
    exp_t e;
    e.sel = s; e.len = l; e.pre = p; e.gap = g;
    sb.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  bit               in_grant = 1'b0;
  int               idle_cnt = 0;
  int               cur_len  = 0;
  logic [SEL_W-1:0] cur_sel  = '0;
  logic [N_SRC-1:0] cur_gnt  = '0;
  exp_t             mon_e;

  always @(negedge clk) begin
    if (!clr) begin
      if (in_grant) begin
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          $display("TXN sel=%0d len=%0d cut by reset (expected sel=%0d)", cur_sel, cur_len, mon_e.sel);
        end
      end
      in_grant = 1'b0;
      idle_cnt = 0;
    end else if (bus_valid) begin
      check("preempt_during_grant", {31'b0, preempt}, 32'd0);
      if (!in_grant) begin
        in_grant = 1'b1;
        cur_sel  = sel;
        cur_gnt  = gnt;
        cur_len  = 1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: actual sel=%0d required no grant", sel);
        end else begin
          check("grant_sel", 32'(sel), 32'(sb[0].sel));
          check("grant_onehot", 32'(gnt), 32'(1) << sb[0].sel);
          if (sb[0].gap >= 0) check("turn_gap", 32'(idle_cnt), 32'(sb[0].gap));
        end
      end else begin
        cur_len++;
        check("grant_stable", {3'b0, gnt, sel}, {3'b0, cur_gnt, cur_sel});
      end
    end else begin
      if (in_grant) begin
        in_grant = 1'b0;
        check("idle_outputs", {3'b0, gnt, sel}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL grant_end_unexpected: actual sel=%0d required no grant", cur_sel);
        end else begin
          mon_e = sb.pop_front();
          check("grant_len", 32'(cur_len), 32'(mon_e.len));
          check("preempt_pulse", {31'b0, preempt}, {31'b0, mon_e.pre});
          $display("TXN sel=%0d len=%0d preempt=%0b gap=%0d", cur_sel, cur_len, preempt, idle_cnt);
        end
        idle_cnt = 1;
      end else begin
        idle_cnt++;
        check("preempt_idle", {31'b0, preempt}, 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset with every request asserted
    clr = 1'b0;
    req = '1;
    wait_neg(3);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
    check("rst_preempt", {31'b0, preempt}, 32'd0);
    req = '0;
    wait_neg(1);
    clr = 1'b1;
    wait_neg(2);

    // 2: single requester, held 3 cycles
    wait_neg(1);
    req = 24'h000020;
    push(5, 3, 1'b0, -1);
    wait_neg(1);
    check("single_gnt", 32'(gnt), 32'h000020);
    wait_neg(2);
    req = '0;
    wait_neg(1);
    check("single_release", {31'b0, bus_valid}, 32'd0);
    wait_neg(4);

    // 3: round robin between 3 and PC after reset
    clr = 1'b0;
    wait_neg(2);
    clr = 1'b1;
    wait_neg(1);
    req = (24'd1 << 3) | (24'd1 << 20);
    push(3, 8, 1'b1, -1);
    push(20, 8, 1'b1, 2);
    push(3, 4, 1'b0, 2);
    wait_neg(24);
    req = '0;
    wait_neg(4);

    // 4: MDR preempted by HI after 8 cycles
    req = 24'd1 << 21;
    push(21, 8, 1'b1, -1);
    push(16, 4, 1'b0, 2);
    wait_neg(2);
    req = req | (24'd1 << 16);
    wait_neg(10);
    req = req & ~(24'd1 << 21);
    wait_neg(2);
    req = '0;
    wait_neg(4);

    // 4b: owner releases on the same edge the hold limit would preempt
    req = 24'd1 << 9;
    push(9, 8, 1'b0, -1);
    push(2, 3, 1'b0, 2);
    wait_neg(3);
    req = req | (24'd1 << 2);
    wait_neg(5);
    req = 24'd1 << 2;
    wait_neg(5);
    req = '0;
    wait_neg(4);

    // 5: C alone for 20 cycles, never preempted
    req = 24'd1 << 23;
    push(23, 20, 1'b0, -1);
    wait_neg(20);
    req = '0;
    wait_neg(4);

    // 6: reset while PC owns the bus
    req = 24'd1 << 20;
    push(20, 0, 1'b0, -1);
    wait_neg(4);
    check("pc_owner", 32'(gnt), 32'd1 << 20);
    #2;
    clr = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_sel", 32'(sel), 32'd0);
    check("async_bus_valid", {31'b0, bus_valid}, 32'd0);
    req = 24'd1 | (24'd1 << 20);
    push(0, 5, 1'b0, -1);
    wait_neg(2);
    clr = 1'b1;
    wait_neg(5);
    req = '0;
    wait_neg(6);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("no_open_grant", {31'b0, in_grant}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
